sap_control_sequencer: RTL

Fetch/decode/execute controller for the SAP CPU. It sits directly upstream of the program counter and drives its PC_COUNT, BRANCH and BRANCH_ADDRESS inputs. It also sequences the MAR, memory, accumulator, ALU flags and output register. Every state advance is qualified by SLOW_CLOCK_STRB, so the whole CPU steps at the slow-clock rate while clocked on CLK.

---
 rtl/sap_control_sequencer_pkg.sv | 53 +++++
 rtl/sap_control_sequencer_if.sv | 35 +++
 rtl/sap_control_sequencer_instr_decode.sv | 53 +++++
 rtl/sap_control_sequencer.sv | 115 +++++++++++
 4 files changed

// File: rtl/sap_control_sequencer_pkg.sv
// Shared definitions for the SAP control sequencer.
// Provides the opcode encodings, the FSM state encoding (which is also the
// STATE debug output), the accumulator source selects and the control word.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [3:0] {
        S_FA  = 4'd0,
        S_FR  = 4'd1,
        S_DEC = 4'd2,
        S_OA  = 4'd3,
        S_OR  = 4'd4,
        S_EA  = 4'd5,
        S_EX  = 4'd6,
        S_JMP = 4'd7,
        S_HLT = 4'd8
    } state_e;

    localparam logic [1:0] A_SRC_MEM = 2'd0;
    localparam logic [1:0] A_SRC_IMM = 2'd1;
    localparam logic [1:0] A_SRC_ALU = 2'd2;

    typedef struct packed {
        logic       pc_count;
        logic       branch;
        logic       mar_load;
        logic       mar_sel;
        logic       mem_we;
        logic       a_load;
        logic [1:0] a_src;
        logic       alu_sub;
        logic       flags_load;
        logic       out_load;
        logic       halted;
    } ctrl_t;

    // Opcodes whose operand byte follows in memory.
    function automatic logic is_two_byte(input logic [3:0] op);
        return (op >= OP_LDA) && (op <= OP_JC);
    endfunction

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Handshake/bus bundle between the SAP sequencer and the rest of the CPU.
// master: the sequencer (drives the control outputs).
// slave : the datapath side (drives strobe, memory data, PC and flags).
interface sap_control_sequencer_if;
    logic       SLOW_CLOCK_STRB;
    logic [7:0] MEM_DATA;
    logic [7:0] PC_VAL;
    logic       ZERO_FLAG;
    logic       CARRY_FLAG;
    logic       PC_COUNT;
    logic       BRANCH;
    logic [7:0] BRANCH_ADDRESS;
    logic       MAR_LOAD;
    logic       MAR_SEL;
    logic       MEM_WE;
    logic       A_LOAD;
    logic [1:0] A_SRC;
    logic       ALU_SUB;
    logic       FLAGS_LOAD;
    logic       OUT_LOAD;
    logic       HALTED;
    logic [3:0] STATE;

    modport master (
        input  SLOW_CLOCK_STRB, MEM_DATA, PC_VAL, ZERO_FLAG, CARRY_FLAG,
        output PC_COUNT, BRANCH, BRANCH_ADDRESS, MAR_LOAD, MAR_SEL, MEM_WE,
               A_LOAD, A_SRC, ALU_SUB, FLAGS_LOAD, OUT_LOAD, HALTED, STATE
    );

    modport slave (
        output SLOW_CLOCK_STRB, MEM_DATA, PC_VAL, ZERO_FLAG, CARRY_FLAG,
        input  PC_COUNT, BRANCH, BRANCH_ADDRESS, MAR_LOAD, MAR_SEL, MEM_WE,
               A_LOAD, A_SRC, ALU_SUB, FLAGS_LOAD, OUT_LOAD, HALTED, STATE
    );
endinterface

// File: rtl/sap_control_sequencer_instr_decode.sv
// sap_instr_decode: combinational map from FSM state and opcode to the
// Moore control word.
// Ports:
//   state_i  - current sequencer state
//   opcode_i - IR[7:4]
//   ctrl_o   - control word
module sap_instr_decode
    import sap_pkg::*;
(
    input  state_e     state_i,
    input  logic [3:0] opcode_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FA:  ctrl_o.mar_load = 1'b1;
            S_FR:  ctrl_o.pc_count = 1'b1;
            S_DEC: ctrl_o.out_load = (opcode_i == OP_OUT);
            S_OA:  ctrl_o.mar_load = 1'b1;
            S_OR:  ctrl_o.pc_count = 1'b1;
            S_EA: begin
                ctrl_o.mar_load = 1'b1;
                ctrl_o.mar_sel  = 1'b1;
            end
            S_EX: begin
                case (opcode_i)
                    OP_LDA: begin
                        ctrl_o.a_load = 1'b1;
                        ctrl_o.a_src  = A_SRC_MEM;
                    end
                    OP_LDI: begin
                        ctrl_o.a_load = 1'b1;
                        ctrl_o.a_src  = A_SRC_IMM;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl_o.a_load     = 1'b1;
                        ctrl_o.a_src      = A_SRC_ALU;
                        ctrl_o.alu_sub    = (opcode_i == OP_SUB);
                        ctrl_o.flags_load = 1'b1;
                    end
                    OP_STA:  ctrl_o.mem_we = 1'b1;
                    default: ;
                endcase
            end
            S_JMP:   ctrl_o.branch = 1'b1;
            S_HLT:   ctrl_o.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: fetch/decode/execute controller for the SAP CPU.
// Holds the state register, IR and operand register; every advance is
// qualified by SLOW_CLOCK_STRB.
// Ports:
//   CLK    - system clock
//   ACLR_L - asynchronous active-low reset
//   bus    - strobe, memory data, flags in; PC/MAR/RAM/ACC/ALU/OUT controls out
//
// state | meaning
// FA    | fetch address: MAR <= PC
// FR    | fetch read: IR <= MEM_DATA, PC++
// DEC   | decode (OUT loads the output register here)
// OA    | operand address: MAR <= PC
// OR    | operand read: OPR <= MEM_DATA, PC++, branch condition sampled
// EA    | execute address: MAR <= OPR
// EX    | execute
// JMP   | PC <= OPR
// HLT   | halted until reset
module sap_control_sequencer
    import sap_pkg::*;
(
    input logic                      CLK,
    input logic                      ACLR_L,
    sap_control_sequencer_if.master  bus
);

    state_e     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] opr_q, opr_d;
    logic [3:0] opcode;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;

    assign opcode = ir_q[7:4];

    always_ff @(posedge CLK or negedge ACLR_L) begin
        if (!ACLR_L) begin
            state_q <= S_FA;
            ir_q    <= '0;
            opr_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        opr_d   = opr_q;
        if (bus.SLOW_CLOCK_STRB) begin
            case (state_q)
                S_FA: state_d = S_FR;
                S_FR: begin
                    ir_d    = bus.MEM_DATA;
                    state_d = S_DEC;
                end
                S_DEC: begin
                    if (is_two_byte(opcode))   state_d = S_OA;
                    else if (opcode == OP_HLT) state_d = S_HLT;
                    else                       state_d = S_FA;
                end
                S_OA: state_d = S_OR;
                S_OR: begin
                    opr_d = bus.MEM_DATA;
                    case (opcode)
                        OP_LDI:                         state_d = S_EX;
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: state_d = S_EA;
                        OP_JMP:                         state_d = S_JMP;
                        OP_JZ:   state_d = bus.ZERO_FLAG  ? S_JMP : S_FA;
                        OP_JC:   state_d = bus.CARRY_FLAG ? S_JMP : S_FA;
                        default:                        state_d = S_FA;
                    endcase
                end
                S_EA:    state_d = S_EX;
                S_EX:    state_d = S_FA;
                S_JMP:   state_d = S_FA;
                S_HLT:   state_d = S_HLT;
                default: state_d = S_FA;
            endcase
        end
    end

    sap_instr_decode u_decode (
        .state_i  (state_q),
        .opcode_i (opcode),
        .ctrl_o   (ctrl)
    );

    // FA is a Moore state with MAR_LOAD high, so controls are forced low
    // directly by the reset pin to keep them quiet while reset is held.
    always_comb begin
        ctrl_out = ACLR_L ? ctrl : '0;
    end

    assign bus.PC_COUNT       = ctrl_out.pc_count;
    assign bus.BRANCH         = ctrl_out.branch;
    assign bus.BRANCH_ADDRESS = (state_q == S_HLT) ? 8'h00 : opr_q;
    assign bus.MAR_LOAD       = ctrl_out.mar_load;
    assign bus.MAR_SEL        = ctrl_out.mar_sel;
    assign bus.MEM_WE         = ctrl_out.mem_we;
    assign bus.A_LOAD         = ctrl_out.a_load;
    assign bus.A_SRC          = ctrl_out.a_src;
    assign bus.ALU_SUB        = ctrl_out.alu_sub;
    assign bus.FLAGS_LOAD     = ctrl_out.flags_load;
    assign bus.OUT_LOAD       = ctrl_out.out_load;
    assign bus.HALTED         = ctrl_out.halted;
    assign bus.STATE          = state_q;

    // IR low nibble and PC_VAL carry no control meaning here.
    logic unused_ok;
    assign unused_ok = ^{ir_q[3:0], bus.PC_VAL};

endmodule
